// File: rtl/base_aforce_seq.sv
// -----------------------------------------------------------------------------
// base_aforce_seq
//
// Multi-channel valid/ready stage. Each channel normally passes its input
// stream straight through to its output with no latency. On a force request
// the channel first lets any stalled pass-through beat leave, then drives
// frc_cnt beats of constant fill data while holding the input off (i_r=0),
// and finally returns to pass-through. Used to terminate aborted transfers
// or pad short ones between a stream source and its consumer.
//
// Parameters
//   width   number of independent channels
//   dwidth  data bits per channel
//   cwidth  force-count bits per channel (max 2^cwidth-1 beats per request)
//   fill    data value driven on every manufactured beat
//
// Ports
//   clk      in   1              clock
//   reset_n  in   1              asynchronous reset, active low
//   frc_v    in   width          force request valid, per channel
//   frc_r    out  width          force request ready (channel in PASS)
//   frc_cnt  in   width*cwidth   beats to manufacture, channel c at [c*cwidth +: cwidth]
//   i_v      in   width          input valid
//   i_r      out  width          input ready
//   i_d      in   width*dwidth   input data
//   o_v      out  width          output valid
//   o_r      in   width          output ready
//   o_d      out  width*dwidth   output data
//   busy     out  width          channel is in ARM or FORCE
//   done     out  width          one-cycle pulse when a force request completes
//   i_l      in   width          end-of-packet flag in  (BASE_AFORCE_LAST_EN only)
//   o_l      out  width          end-of-packet flag out (BASE_AFORCE_LAST_EN only)
//
// Configuration macro
//   BASE_AFORCE_LAST_EN  adds i_l/o_l; while forcing, o_l marks only the final
//                        manufactured beat.
// -----------------------------------------------------------------------------
module base_aforce_seq #(
   parameter int                width  = 1,
   parameter int                dwidth = 8,
   parameter int                cwidth = 8,
   parameter logic [dwidth-1:0] fill   = {dwidth{1'b0}}
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [width-1:0]         frc_v,
   output logic [width-1:0]         frc_r,
   input  logic [width*cwidth-1:0]  frc_cnt,
   input  logic [width-1:0]         i_v,
   output logic [width-1:0]         i_r,
   input  logic [width*dwidth-1:0]  i_d,
   output logic [width-1:0]         o_v,
   input  logic [width-1:0]         o_r,
   output logic [width*dwidth-1:0]  o_d,
`ifdef BASE_AFORCE_LAST_EN
   input  logic [width-1:0]         i_l,
   output logic [width-1:0]         o_l,
`endif
   output logic [width-1:0]         busy,
   output logic [width-1:0]         done
);

   typedef enum logic [1:0] {
      ST_PASS  = 2'b00,
      ST_ARM   = 2'b01,
      ST_FORCE = 2'b10
   } state_t;

   localparam logic [cwidth-1:0] cnt_zero = {cwidth{1'b0}};
   localparam logic [cwidth-1:0] cnt_one  = cwidth'(1'b1);

   for (genvar c = 0; c < width; c++) begin : g_ch

      state_t              state;
      logic [cwidth-1:0]   remaining;
      logic                done_q;
      logic                busy_q;
      logic [cwidth-1:0]   cnt_in;
      logic                ch_ov;
      logic                ch_ir;
      logic [dwidth-1:0]   ch_od;

      assign cnt_in = frc_cnt[c*cwidth +: cwidth];

      // Channel FSM: request acceptance, drain of a stalled beat, forced beat count.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            state     <= ST_PASS;
            remaining <= cnt_zero;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
         end else begin
            done_q <= 1'b0;
            case (state)
               ST_PASS: begin
                  if (frc_v[c]) begin
                     remaining <= cnt_in;
                     if (cnt_in == cnt_zero) begin
                        // Empty request: complete immediately, nothing manufactured.
                        done_q <= 1'b1;
                     end else if (i_v[c] && !o_r[c]) begin
                        // A beat is stalled on the output; let it leave first.
                        state  <= ST_ARM;
                        busy_q <= 1'b1;
                     end else begin
                        state  <= ST_FORCE;
                        busy_q <= 1'b1;
                     end
                  end
               end
               ST_ARM: begin
                  if ((i_v[c] && o_r[c]) || !i_v[c]) begin
                     state <= ST_FORCE;
                  end
               end
               ST_FORCE: begin
                  if (o_r[c]) begin
                     // Decrement only while nonzero; a count of 0 here can only
                     // come from corruption and is treated as the last beat.
                     if (remaining != cnt_zero) begin
                        remaining <= remaining - cnt_one;
                     end
                     if (remaining <= cnt_one) begin
                        state  <= ST_PASS;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                     end
                  end
               end
               default: begin
                  state     <= ST_PASS;
                  remaining <= cnt_zero;
                  busy_q    <= 1'b0;
               end
            endcase
         end
      end

      // Output steering: zero-latency pass-through unless manufacturing beats.
      always_comb begin
         ch_ov = i_v[c];
         ch_ir = o_r[c];
         ch_od = i_d[c*dwidth +: dwidth];
         case (state)
            ST_FORCE: begin
               ch_ov = 1'b1;
               ch_ir = 1'b0;
               ch_od = fill;
            end
            default: begin
               ch_ov = i_v[c];
               ch_ir = o_r[c];
               ch_od = i_d[c*dwidth +: dwidth];
            end
         endcase
      end

      assign o_v[c]                  = ch_ov;
      assign i_r[c]                  = ch_ir;
      assign o_d[c*dwidth +: dwidth] = ch_od;
      assign frc_r[c]                = (state == ST_PASS);
      assign busy[c]                 = busy_q;
      assign done[c]                 = done_q;

`ifdef BASE_AFORCE_LAST_EN
      logic ch_ol;

      // End-of-packet flag: passed through, or set on the final forced beat only.
      always_comb begin
         ch_ol = i_l[c];
         if (state == ST_FORCE) begin
            ch_ol = (remaining == cnt_one);
         end else begin
            ch_ol = i_l[c];
         end
      end

      assign o_l[c] = ch_ol;
`endif

   end

endmodule

// File: tb/tb_base_aforce_seq.sv
// -----------------------------------------------------------------------------
// tb_base_aforce_seq
//
// Self-checking bench for base_aforce_seq with two channels. A behavioural
// model tracks, per channel, how many fill beats are still owed, whether the
// channel is still waiting for a stalled beat to leave, and whether a done
// pulse is due. Every cycle all outputs are compared against that model.
// -----------------------------------------------------------------------------
module tb_base_aforce_seq;

   localparam int              W    = 2;
   localparam int              DW   = 8;
   localparam int              CW   = 8;
   localparam logic [DW-1:0]   FILL = 8'hC3;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [W-1:0]      frc_v;
   logic [W-1:0]      frc_r;
   logic [W*CW-1:0]   frc_cnt;
   logic [W-1:0]      i_v;
   logic [W-1:0]      i_r;
   logic [W*DW-1:0]   i_d;
   logic [W-1:0]      o_v;
   logic [W-1:0]      o_r;
   logic [W*DW-1:0]   o_d;
   logic [W-1:0]      busy;
   logic [W-1:0]      done;
`ifdef BASE_AFORCE_LAST_EN
   logic [W-1:0]      i_l;
   logic [W-1:0]      o_l;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model: owed fill beats, waiting-for-drain flag, done due.
   int m_left [W];
   bit m_wait [W];
   bit m_done [W];

   base_aforce_seq #(
      .width  (W),
      .dwidth (DW),
      .cwidth (CW),
      .fill   (FILL)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .frc_v   (frc_v),
      .frc_r   (frc_r),
      .frc_cnt (frc_cnt),
      .i_v     (i_v),
      .i_r     (i_r),
      .i_d     (i_d),
      .o_v     (o_v),
      .o_r     (o_r),
      .o_d     (o_d),
`ifdef BASE_AFORCE_LAST_EN
      .i_l     (i_l),
      .o_l     (o_l),
`endif
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < W; c++) begin
         m_left[c] = 0;
         m_wait[c] = 1'b0;
         m_done[c] = 1'b0;
      end
   endtask

   task automatic check_all(input string tag);
      for (int c = 0; c < W; c++) begin
         bit forcing;
         forcing = (m_left[c] > 0) && !m_wait[c];
         chk($sformatf("%s ch%0d o_v", tag, c), {31'd0, o_v[c]}, {31'd0, forcing | i_v[c]});
         chk($sformatf("%s ch%0d i_r", tag, c), {31'd0, i_r[c]}, {31'd0, !forcing & o_r[c]});
         chk($sformatf("%s ch%0d o_d", tag, c), {24'd0, o_d[c*DW +: DW]},
             {24'd0, forcing ? FILL : i_d[c*DW +: DW]});
         chk($sformatf("%s ch%0d busy", tag, c), {31'd0, busy[c]}, {31'd0, m_left[c] > 0});
         chk($sformatf("%s ch%0d frc_r", tag, c), {31'd0, frc_r[c]}, {31'd0, m_left[c] == 0});
         chk($sformatf("%s ch%0d done", tag, c), {31'd0, done[c]}, {31'd0, m_done[c]});
`ifdef BASE_AFORCE_LAST_EN
         chk($sformatf("%s ch%0d o_l", tag, c), {31'd0, o_l[c]},
             {31'd0, forcing ? (m_left[c] == 1) : i_l[c]});
`endif
      end
   endtask

   // Advance the model by one clock edge using the inputs presented this cycle.
   task automatic model_clock();
      for (int c = 0; c < W; c++) begin
         bit nd;
         int cnt;
         nd  = 1'b0;
         cnt = int'(frc_cnt[c*CW +: CW]);
         if (m_left[c] == 0) begin
            if (frc_v[c]) begin
               if (cnt == 0) begin
                  nd = 1'b1;
               end else begin
                  m_left[c] = cnt;
                  m_wait[c] = i_v[c] & ~o_r[c];
               end
            end
         end else if (m_wait[c]) begin
            if (!i_v[c] || o_r[c]) m_wait[c] = 1'b0;
         end else if (o_r[c]) begin
            m_left[c] = m_left[c] - 1;
            if (m_left[c] == 0) nd = 1'b1;
         end
         m_done[c] = nd;
      end
   endtask

   // One cycle: check outputs on the falling edge, then clock the model.
   task automatic step(input string tag);
      @(negedge clk);
      check_all(tag);
      @(posedge clk);
      model_clock();
      #1;
   endtask

   task automatic set_ch(input int c, input bit fv, input int cnt, input bit iv,
                         input bit orr, input logic [DW-1:0] d);
      frc_v[c]            = fv;
      frc_cnt[c*CW +: CW] = cnt[CW-1:0];
      i_v[c]              = iv;
      o_r[c]              = orr;
      i_d[c*DW +: DW]     = d;
`ifdef BASE_AFORCE_LAST_EN
      i_l[c]              = 1'($urandom_range(0, 1));
`endif
   endtask

   initial begin
      reset_n = 1'b0;
      frc_v   = '0;
      frc_cnt = '0;
      i_v     = '0;
      o_r     = '0;
      i_d     = '0;
`ifdef BASE_AFORCE_LAST_EN
      i_l     = '0;
`endif
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      reset_n = 1'b1;

      // 1: plain pass-through
      set_ch(0, 1'b0, 0, 1'b1, 1'b1, 8'h5A);
      set_ch(1, 1'b0, 0, 1'b1, 1'b0, 8'h11);
      step("t1_pass");

      // 2: three forced beats, then a new request in the done cycle
      set_ch(0, 1'b1, 3, 1'b1, 1'b1, 8'h21);
      step("t2_accept");
      set_ch(0, 1'b0, 0, 1'b1, 1'b1, 8'h22);
      repeat (3) step("t2_force");
      set_ch(0, 1'b1, 1, 1'b0, 1'b1, 8'h23);
      step("t2_done_reaccept");
      set_ch(0, 1'b0, 0, 1'b0, 1'b1, 8'h24);
      repeat (2) step("t2_tail");

      // 3: stalled beat drains before two forced beats
      set_ch(0, 1'b1, 2, 1'b1, 1'b0, 8'h77);
      step("t3_accept");
      set_ch(0, 1'b0, 0, 1'b1, 1'b0, 8'h77);
      step("t3_arm_hold");
      set_ch(0, 1'b0, 0, 1'b1, 1'b1, 8'h77);
      step("t3_drain");
      set_ch(0, 1'b0, 0, 1'b1, 1'b0, 8'h78);
      step("t3_force_stall");
      set_ch(0, 1'b0, 0, 1'b1, 1'b1, 8'h78);
      repeat (3) step("t3_force");

      // 4: zero-count request
      set_ch(0, 1'b1, 0, 1'b1, 1'b0, 8'h3C);
      step("t4_accept");
      set_ch(0, 1'b0, 0, 1'b0, 1'b1, 8'h3D);
      repeat (2) step("t4_after");

      // 5: reset while forcing with two beats left
      set_ch(0, 1'b1, 3, 1'b0, 1'b1, 8'h44);
      step("t5_accept");
      set_ch(0, 1'b0, 0, 1'b1, 1'b1, 8'h45);
      step("t5_force");
      reset_n = 1'b0;
      #1;
      model_reset();
      check_all("t5_rst_mid");
      @(negedge clk);
      reset_n = 1'b1;
      set_ch(0, 1'b0, 0, 1'b1, 1'b1, 8'h46);
      @(posedge clk);
      model_clock();
      #1;
      step("t5_after_rst");
      set_ch(0, 1'b1, 2, 1'b0, 1'b1, 8'h47);
      step("t5_reaccept");
      set_ch(0, 1'b0, 0, 1'b0, 1'b1, 8'h48);
      repeat (3) step("t5_force2");

      // 6: ch0 forced four beats while ch1 passes with toggling o_r
      set_ch(0, 1'b1, 4, 1'b0, 1'b1, 8'h00);
      set_ch(1, 1'b0, 0, 1'b1, 1'b1, 8'h90);
      step("t6_accept");
      for (int k = 0; k < 6; k++) begin
         set_ch(0, 1'b0, 0, 1'($urandom_range(0, 1)), 1'b1, 8'($urandom));
         set_ch(1, 1'b0, 0, 1'b1, 1'(k % 2), 8'($urandom));
         step("t6_run");
      end

      // Random traffic on both channels
      for (int k = 0; k < 400; k++) begin
         for (int c = 0; c < W; c++) begin
            set_ch(c, ($urandom_range(0, 5) == 0), int'($urandom_range(0, 5)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
         end
         step("rand");
      end

      // Maximum count on ch1 with random back-pressure
      for (int c = 0; c < W; c++) set_ch(c, 1'b0, 0, 1'b0, 1'b1, 8'h00);
      step("max_idle");
      set_ch(1, 1'b1, 255, 1'b0, 1'b1, 8'h55);
      step("max_accept");
      for (int k = 0; k < 600; k++) begin
         set_ch(0, 1'b0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
         set_ch(1, 1'b0, 0, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 8'($urandom));
         step("max_run");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
